// File: rtl/player_status_manager.sv
// Player state tracker: lives, 2-digit BCD score, post-hit invulnerability window and game FSM.
// Latency: every output is registered and reflects an input event one clk after it is sampled.
// Backpressure: none; all event inputs are consumed unconditionally on the clk they are seen.
module player_status_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 32
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       hit_pulse,
    input  logic       heart_collision,
    input  logic       start_key,
    output logic [2:0] lives,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       invulnerable,
    output logic       blink,
    output logic       game_over,
    output logic       game_active
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_INVULN,
        ST_GAME_OVER
    } state_t;

    localparam logic [2:0] INIT_L = 3'(INIT_LIVES);
    localparam logic [2:0] MAX_L  = 3'(MAX_LIVES);
    localparam logic [7:0] INV_L  = 8'(INVULN_FRAMES);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] lives_nxt;
    logic [2:0] lives_bonus;
    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;
    logic [7:0] inv_cnt;
    logic [7:0] inv_nxt;
    logic       heart_seen;
    logic       heart_nxt;
    logic       in_game;
    logic       bonus;

    // Hearts only count while a game is running; the bonus is granted on the frame boundary.
    assign in_game     = (state == ST_PLAY) || (state == ST_INVULN);
    assign bonus       = startOfFrame && heart_seen && in_game;
    assign lives_bonus = !bonus ? lives : ((lives >= MAX_L) ? MAX_L : lives + 3'd1);

    // Next-state logic: the bonus is folded in first, then the FSM acts on the bonused lives.
    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        ones_nxt  = score_ones;
        tens_nxt  = score_tens;
        inv_nxt   = inv_cnt;
        heart_nxt = heart_seen;

        // An overlap on the startOfFrame clk belongs to the frame that is just starting.
        if (in_game) begin
            heart_nxt = startOfFrame ? heart_collision : (heart_seen | heart_collision);
        end

        // BCD score increment, saturating at 99.
        if (bonus) begin
            if (score_ones == 4'd9) begin
                if (score_tens != 4'd9) begin
                    ones_nxt = 4'd0;
                    tens_nxt = score_tens + 4'd1;
                end
            end else begin
                ones_nxt = score_ones + 4'd1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (start_key) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                lives_nxt = lives_bonus;
                if (hit_pulse) begin
                    if (lives_bonus <= 3'd1) begin
                        state_nxt = ST_GAME_OVER;
                        lives_nxt = 3'd0;
                        heart_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_INVULN;
                        lives_nxt = lives_bonus - 3'd1;
                        inv_nxt   = INV_L;
                    end
                end
            end
            ST_INVULN: begin
                lives_nxt = lives_bonus;
                if (startOfFrame) begin
                    if (inv_cnt <= 8'd1) begin
                        inv_nxt   = 8'd0;
                        state_nxt = ST_PLAY;
                    end else begin
                        inv_nxt = inv_cnt - 8'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_key) begin
                    state_nxt = ST_PLAY;
                    lives_nxt = INIT_L;
                    ones_nxt  = 4'd0;
                    tens_nxt  = 4'd0;
                    heart_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state so they stay aligned.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ST_IDLE;
            lives        <= INIT_L;
            score_ones   <= 4'd0;
            score_tens   <= 4'd0;
            inv_cnt      <= 8'd0;
            heart_seen   <= 1'b0;
            invulnerable <= 1'b0;
            blink        <= 1'b0;
            game_over    <= 1'b0;
            game_active  <= 1'b0;
        end else begin
            state        <= state_nxt;
            lives        <= lives_nxt;
            score_ones   <= ones_nxt;
            score_tens   <= tens_nxt;
            inv_cnt      <= inv_nxt;
            heart_seen   <= heart_nxt;
            invulnerable <= (state_nxt == ST_INVULN);
            blink        <= (state_nxt == ST_INVULN) && inv_nxt[2];
            game_over    <= (state_nxt == ST_GAME_OVER);
            game_active  <= (state_nxt == ST_PLAY) || (state_nxt == ST_INVULN);
        end
    end

endmodule
